// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct constants, ULA control codes and datapath mux selects.
package uc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ULA_W   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ULA_W-1:0] ULA_ADD = 3'b010;
  localparam logic [ULA_W-1:0] ULA_SUB = 3'b110;
  localparam logic [ULA_W-1:0] ULA_AND = 3'b000;
  localparam logic [ULA_W-1:0] ULA_OR  = 3'b001;
  localparam logic [ULA_W-1:0] ULA_SLT = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ULA    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_ula.sv
// decodificador_ula: combinational Funct -> ULA_Control map.
// Ports: funct (R-type function field), ula_control (ULA operation code),
// valid (funct is one of add/sub/and/or/slt).
module decodificador_ula
  import uc_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ULA_W-1:0]   ula_control,
  output logic               valid
);

  always_comb begin
    ula_control = ULA_ADD;
    valid       = 1'b1;
    case (funct)
      FUNCT_ADD: ula_control = ULA_ADD;
      FUNCT_SUB: ula_control = ULA_SUB;
      FUNCT_AND: ula_control = ULA_AND;
      FUNCT_OR:  ula_control = ULA_OR;
      FUNCT_SLT: ula_control = ULA_SLT;
      default:   valid       = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: Moore control FSM sequencing the shared
// multicycle MIPS datapath (lw, sw, beq, addi, j, R-type add/sub/and/or/slt),
// stalling in FETCH/MEMRD/MEMWR until mem_ready.
// Ports: clk, reset (async, active-high), OP/Funct from IR, mem_ready
// handshake; datapath controls IorD, MemWrite, IRWrite, PCWrite, Branch,
// PCSrc, ULASrcA, ULASrcB, ULA_Control, RegDst, MemtoReg, RegWrite, and the
// Illegal pulse raised in DECODE for unsupported instructions.
// Optional feature macro UC_BNE_EN: adds bne support and the BranchNe output.
module unidade_controle_multiciclo
  import uc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    OP,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic [SEL_W-1:0]   PCSrc,
  output logic               ULASrcA,
  output logic [SEL_W-1:0]   ULASrcB,
  output logic [ULA_W-1:0]   ULA_Control,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               Illegal
`ifdef UC_BNE_EN
  ,
  output logic               BranchNe
`endif
);

  state_t           state;
  logic [ULA_W-1:0] funct_ctl;
  logic             funct_ok;
  logic             op_ok;

  decodificador_ula u_dec (
    .funct       (Funct),
    .ula_control (funct_ctl),
    .valid       (funct_ok)
  );

  // Instruction legality, shared by the DECODE transition and Illegal.
  always_comb begin
    op_ok = 1'b0;
    case (OP)
      OP_RTYPE: op_ok = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
`ifdef UC_BNE_EN
      OP_BNE: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // State register and transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (!op_ok) begin
            state <= S_FETCH;
          end else begin
            case (OP)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= S_EXECUTE;
              OP_BEQ:       state <= S_BRANCH;
`ifdef UC_BNE_EN
              OP_BNE:       state <= S_BRANCH;
`endif
              OP_ADDI:      state <= S_ADDIEXEC;
              OP_J:         state <= S_JUMP;
              default:      state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:   state <= (OP == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_ready) state <= S_MEMWB;
        S_MEMWR:    if (mem_ready) state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEXEC: state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; mem_ready only gates the FETCH loads, and those
  // stay low while reset is held so the reset image is the idle FETCH.
  always_comb begin
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    PCSrc       = PCSRC_ULA;
    ULASrcA     = 1'b0;
    ULASrcB     = SRCB_B;
    ULA_Control = ULA_AND;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Illegal     = 1'b0;
`ifdef UC_BNE_EN
    BranchNe    = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        ULASrcB     = SRCB_FOUR;
        ULA_Control = ULA_ADD;
        IRWrite     = mem_ready & ~reset;
        PCWrite     = mem_ready & ~reset;
      end
      S_DECODE: begin
        ULASrcB     = SRCB_IMM_SH;
        ULA_Control = ULA_ADD;
        Illegal     = ~op_ok;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ULASrcA     = 1'b1;
        ULASrcB     = SRCB_IMM;
        ULA_Control = ULA_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ULASrcA     = 1'b1;
        ULA_Control = funct_ctl;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ULASrcA     = 1'b1;
        ULA_Control = ULA_SUB;
        PCSrc       = PCSRC_ULAOUT;
`ifdef UC_BNE_EN
        if (OP == OP_BNE) BranchNe = 1'b1;
        else              Branch   = 1'b1;
`else
        Branch      = 1'b1;
`endif
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for unidade_controle_multiciclo: table of per-cycle vectors
// {reset, OP, Funct, mem_ready, expected outputs}, plus cycle-count and
// asynchronous-reset sequences.
module tb_unidade_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0] PCSrc;
  logic       ULASrcA;
  logic [1:0] ULASrcB;
  logic [2:0] ULA_Control;
  logic       RegDst, MemtoReg, RegWrite, Illegal;
`ifdef UC_BNE_EN
  logic       BranchNe;
`endif

  unidade_controle_multiciclo dut (
    .clk         (clk),
    .reset       (reset),
    .OP          (OP),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .Branch      (Branch),
    .PCSrc       (PCSrc),
    .ULASrcA     (ULASrcA),
    .ULASrcB     (ULASrcB),
    .ULA_Control (ULA_Control),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .Illegal     (Illegal)
`ifdef UC_BNE_EN
    ,
    .BranchNe    (BranchNe)
`endif
  );

  always #5 clk = ~clk;

  // {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ULASrcA, ULASrcB,
  //  ULA_Control, RegDst, MemtoReg, RegWrite, Illegal}
  localparam logic [16:0] E_RESET    = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
  localparam logic [16:0] E_FETCH_R  = {5'b00110, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
  localparam logic [16:0] E_FETCH_W  = E_RESET;
  localparam logic [16:0] E_DEC      = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0000};
  localparam logic [16:0] E_DEC_ILL  = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0001};
  localparam logic [16:0] E_MEMADR   = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
  localparam logic [16:0] E_MEMRD    = {5'b10000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_MEMWB    = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0110};
  localparam logic [16:0] E_MEMWR    = {5'b11000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_EXEC_SUB = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b110, 4'b0000};
  localparam logic [16:0] E_EXEC_SLT = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 4'b0000};
  localparam logic [16:0] E_ALUWB    = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1010};
  localparam logic [16:0] E_BRANCH   = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
  localparam logic [16:0] E_ADDIEX   = E_MEMADR;
  localparam logic [16:0] E_ADDIWB   = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0010};
  localparam logic [16:0] E_JUMP     = {5'b00010, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   checks = 0;
  int   passed = 0;

  function automatic logic [16:0] outs();
    return {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ULASrcA, ULASrcB,
            ULA_Control, RegDst, MemtoReg, RegWrite, Illegal};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                     input logic mr, input logic [16:0] exp);
    vecs[nvec].rst   = rst;
    vecs[nvec].op    = op;
    vecs[nvec].funct = funct;
    vecs[nvec].mr    = mr;
    vecs[nvec].exp   = exp;
    nvec++;
  endtask

  task automatic check_outs(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = outs();
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Runs one instruction from FETCH (mem_ready=1) and counts cycles until
  // FETCH loads the next instruction; must start just after a posedge in FETCH.
  task automatic count_cycles(input string name, input logic [5:0] op,
                              input logic [5:0] funct, input int exp_cycles);
    int n;
    n = 0;
    OP = op; Funct = funct; mem_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!IRWrite && n < 20);
    checks++;
    if (n == exp_cycles && IRWrite) passed++;
    else $display("FAIL cycles_%s: got %0d expected %0d", name, n, exp_cycles);
  endtask

  initial begin
    reset = 1'b1; OP = 6'd0; Funct = 6'd0; mem_ready = 1'b0;

    add(1, 6'b100011, 6'd0, 1, E_RESET);
    add(1, 6'b100011, 6'd0, 0, E_RESET);
    // lw, no waits
    add(0, 6'b100011, 6'd0, 1, E_FETCH_R);
    add(0, 6'b100011, 6'd0, 1, E_DEC);
    add(0, 6'b100011, 6'd0, 1, E_MEMADR);
    add(0, 6'b100011, 6'd0, 1, E_MEMRD);
    add(0, 6'b100011, 6'd0, 0, E_MEMWB);
    // sw with one FETCH wait and three MEMWR waits
    add(0, 6'b101011, 6'd0, 0, E_FETCH_W);
    add(0, 6'b101011, 6'd0, 1, E_FETCH_R);
    add(0, 6'b101011, 6'd0, 0, E_DEC);
    add(0, 6'b101011, 6'd0, 0, E_MEMADR);
    add(0, 6'b101011, 6'd0, 0, E_MEMWR);
    add(0, 6'b101011, 6'd0, 0, E_MEMWR);
    add(0, 6'b101011, 6'd0, 0, E_MEMWR);
    add(0, 6'b101011, 6'd0, 1, E_MEMWR);
    // R-type sub
    add(0, 6'b000000, 6'b100010, 1, E_FETCH_R);
    add(0, 6'b000000, 6'b100010, 1, E_DEC);
    add(0, 6'b000000, 6'b100010, 0, E_EXEC_SUB);
    add(0, 6'b000000, 6'b100010, 1, E_ALUWB);
    // illegal opcode, then illegal funct
    add(0, 6'b111111, 6'd0, 1, E_FETCH_R);
    add(0, 6'b111111, 6'd0, 1, E_DEC_ILL);
    add(0, 6'b000000, 6'd0, 1, E_FETCH_R);
    add(0, 6'b000000, 6'd0, 1, E_DEC_ILL);
    // beq
    add(0, 6'b000100, 6'd0, 1, E_FETCH_R);
    add(0, 6'b000100, 6'd0, 0, E_DEC);
    add(0, 6'b000100, 6'd0, 1, E_BRANCH);
    // j
    add(0, 6'b000010, 6'd0, 1, E_FETCH_R);
    add(0, 6'b000010, 6'd0, 1, E_DEC);
    add(0, 6'b000010, 6'd0, 0, E_JUMP);
    // addi
    add(0, 6'b001000, 6'd0, 1, E_FETCH_R);
    add(0, 6'b001000, 6'd0, 1, E_DEC);
    add(0, 6'b001000, 6'd0, 1, E_ADDIEX);
    add(0, 6'b001000, 6'd0, 1, E_ADDIWB);
`ifndef UC_BNE_EN
    // bne opcode is unsupported in the default build
    add(0, 6'b000101, 6'd0, 1, E_FETCH_R);
    add(0, 6'b000101, 6'd0, 1, E_DEC_ILL);
`endif
    // R-type slt
    add(0, 6'b000000, 6'b101010, 1, E_FETCH_R);
    add(0, 6'b000000, 6'b101010, 1, E_DEC);
    add(0, 6'b000000, 6'b101010, 1, E_EXEC_SLT);
    add(0, 6'b000000, 6'b101010, 1, E_ALUWB);
    // lw with one MEMRD wait
    add(0, 6'b100011, 6'd0, 1, E_FETCH_R);
    add(0, 6'b100011, 6'd0, 1, E_DEC);
    add(0, 6'b100011, 6'd0, 1, E_MEMADR);
    add(0, 6'b100011, 6'd0, 0, E_MEMRD);
    add(0, 6'b100011, 6'd0, 1, E_MEMRD);
    add(0, 6'b100011, 6'd0, 1, E_MEMWB);

    #1;
    for (int i = 0; i < nvec; i++) begin
      reset = vecs[i].rst; OP = vecs[i].op; Funct = vecs[i].funct; mem_ready = vecs[i].mr;
      @(negedge clk);
      check_outs($sformatf("vec[%0d]", i), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Cycle counts with zero wait states (state is FETCH here).
    count_cycles("lw",   6'b100011, 6'd0,      5);
    count_cycles("sw",   6'b101011, 6'd0,      4);
    count_cycles("add",  6'b000000, 6'b100000, 4);
    count_cycles("addi", 6'b001000, 6'd0,      4);
    count_cycles("beq",  6'b000100, 6'd0,      3);
    count_cycles("j",    6'b000010, 6'd0,      3);
    count_cycles("ill",  6'b111111, 6'd0,      2);

    // Asynchronous reset while sw waits in MEMWR.
    OP = 6'b101011; Funct = 6'd0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check_outs("memwr_before_reset", E_MEMWR);
    reset = 1'b1;
    #1;
    check_outs("async_reset_drop", E_RESET);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    check_outs("fetch_after_reset", E_FETCH_R);
    @(posedge clk); #1;
    check_outs("decode_after_reset", E_DEC);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
